// File: rtl/mult_div_unit.sv
// mult_div_unit: HI/LO multiply/divide unit with a fixed-latency busy window.
// Results are computed from latched operands and committed on the last busy edge.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_d, lo_d;

    logic [63:0] mul_a, mul_b, product;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

    assign busy = (state_q == S_BUSY);

    // Datapath: product and quotient/remainder from the latched operands
    always_comb begin
        mul_a   = (op_q == OP_MULT) ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
        mul_b   = (op_q == OP_MULT) ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
        product = mul_a * mul_b;
        // Signed divide runs on magnitudes; -0x80000000 stays 0x80000000 as an
        // unsigned magnitude, which makes 0x80000000 / -1 yield 0x80000000.
        a_neg   = (op_q == OP_DIV) && a_q[31];
        b_neg   = (op_q == OP_DIV) && b_q[31];
        a_mag   = a_neg ? -a_q : a_q;
        b_mag   = b_neg ? -b_q : b_q;
        q_mag   = '0;
        r_mag   = '0;
        if (b_q != '0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quot    = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem     = a_neg ? -r_mag : r_mag;
    end

    // Next-state: request acceptance, countdown and result commit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi;
        lo_d    = lo;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_d = S_BUSY;
                            cnt_d   = (op == OP_MULT || op == OP_MULTU) ?
                                      5'(MULT_CYCLES) : 5'(DIV_CYCLES);
                            op_d    = op;
                            a_d     = a;
                            b_d     = b;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                if (cnt_q == 5'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    if (op_q == OP_MULT || op_q == OP_MULTU) begin
                        hi_d = product[63:32];
                        lo_d = product[31:0];
                    end else if (b_q != '0) begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, operand latch and HI/LO registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi      <= hi_d;
            lo      <= lo_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors with hand-computed HI/LO/busy expectations.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one mult/div op, scramble operands during busy, check the window and result.
    task automatic run_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                          input int n, input logic [31:0] new_hi, input logic [31:0] new_lo);
        @(negedge clk);
        start = 1'b1; op = o; a = va; b = vb;
        @(negedge clk);
        start = 1'b0; a = 32'h5A5A_1234; b = 32'h0000_0000;
        for (int i = 0; i < n; i++) begin
            check("busy_window", 32'(busy), 32'd1);
            check("hi_hold", hi, exp_hi);
            check("lo_hold", lo, exp_lo);
            if (i < n - 1) @(negedge clk);
        end
        @(negedge clk);
        exp_hi = new_hi;
        exp_lo = new_lo;
        check("busy_done", 32'(busy), 32'd0);
        check("hi_result", hi, exp_hi);
        check("lo_result", lo, exp_lo);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        exp_hi = '0; exp_lo = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);

        run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 5, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
        run_op(3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op(3'd3, 32'h0000_0064, 32'h0000_0007, 10, 32'h0000_0002, 32'h0000_000E);
        run_op(3'd3, 32'hFFFF_FFFF, 32'h0000_0010, 10, 32'h0000_000F, 32'h0FFF_FFFF);

        // mtlo then divide by zero leaves HI/LO untouched
        @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        exp_lo = 32'h1234_5678;
        check("mtlo_lo", lo, exp_lo);
        check("mtlo_hi", hi, exp_hi);
        check("mtlo_busy", 32'(busy), 32'd0);
        run_op(3'd3, 32'h0000_0055, 32'h0000_0000, 10, exp_hi, exp_lo);

        // mthi
        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 32'hCAFE_F00D;
        @(negedge clk);
        start = 1'b0;
        exp_hi = 32'hCAFE_F00D;
        check("mthi_hi", hi, exp_hi);
        check("mthi_lo", lo, exp_lo);
        check("mthi_busy", 32'(busy), 32'd0);

        // reserved ops ignored
        @(negedge clk);
        start = 1'b1; op = 3'd6; a = 32'h1111_1111; b = 32'h2;
        @(negedge clk);
        op = 3'd7;
        @(negedge clk);
        start = 1'b0;
        check("rsv_busy", 32'(busy), 32'd0);
        check("rsv_hi", hi, exp_hi);
        check("rsv_lo", lo, exp_lo);

        // reset mid-run
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst2_hi", hi, 32'h0);
        check("rst2_lo", lo, 32'h0);

        // requests during busy are ignored
        start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        check("ign_busy1", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
        @(negedge clk);
        check("ign_mthi_hi", hi, 32'h0);
        op = 3'd0; a = 32'd5; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("ign_busy5", 32'(busy), 32'd1);
        @(negedge clk);
        check("ign_done_busy", 32'(busy), 32'd0);
        check("ign_hi", hi, 32'h0);
        check("ign_lo", lo, 32'h0000_000C);
        @(negedge clk);
        check("ign_no_restart", 32'(busy), 32'd0);
        check("ign_lo_keep", lo, 32'h0000_000C);

        // start held through completion: re-accepted one cycle after busy falls
        start = 1'b1; op = 3'd1; a = 32'd2; b = 32'd3;
        repeat (5) @(negedge clk);
        check("held_busy_last", 32'(busy), 32'd1);
        @(negedge clk);
        check("held_done_busy", 32'(busy), 32'd0);
        check("held_lo", lo, 32'd6);
        @(negedge clk);
        check("held_reaccept", 32'(busy), 32'd1);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("held2_busy", 32'(busy), 32'd0);
        check("held2_lo", lo, 32'd6);
        check("held2_hi", hi, 32'd0);

        // reset wins over a simultaneous request
        reset = 1'b1; start = 1'b1; op = 3'd5; a = 32'hAAAA_AAAA;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        check("rstprio_lo", lo, 32'h0);
        check("rstprio_busy", 32'(busy), 32'd0);

        // reset in busy cycle 3 aborts a divide
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        repeat (10) @(negedge clk);
        check("abort_late_busy", 32'(busy), 32'd0);
        check("abort_late_hi", hi, 32'h0);
        check("abort_late_lo", lo, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
